// File: rtl/key_reset_sequencer_if.sv
// Key/reset bundle between the push-button front end and its consumers.
// master = sequencer side, slave = board/probe side.
interface key_reset_sequencer_if;
  logic       key_raw;
  logic       core_rst;
  logic       key_level;
  logic       press_pulse;
  logic [7:0] reset_count;

  modport master (
    input  key_raw,
    output core_rst,
    output key_level,
    output press_pulse,
    output reset_count
  );

  modport slave (
    output key_raw,
    input  core_rst,
    input  key_level,
    input  press_pulse,
    input  reset_count
  );
endinterface

// File: rtl/key_reset_sequencer.sv
// Push-button reset front end: sync, debounce, stretched core reset.
// core_rst is a flop fed from the next-state decode, never raw logic.
module key_reset_sequencer #(
  parameter int DEBOUNCE_CYCLES   = 8,
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int KEY_ACTIVE_LOW    = 1,
  parameter int CNT_W             = 20
) (
  input  logic clk,
  input  logic rst,
  key_reset_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_PRESS,
    S_STRETCH
  } state_t;

  localparam int HW =
    (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic IDLE_RAW = (KEY_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DEB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] INIT_LAST =
    HW'(RESET_HOLD_CYCLES - 1);
  // The PRESS cycle that observes the release is the first hold cycle.
  localparam logic [HW-1:0] STR_LAST =
    HW'((RESET_HOLD_CYCLES > 1) ? RESET_HOLD_CYCLES - 2 : 0);

  logic             sync0;
  logic             sync1;
  logic             key_sync;
  logic [CNT_W-1:0] deb_cnt;
  logic             level_q;
  logic             press_q;
  logic [7:0]       count_q;
  logic             accept;
  state_t           state;
  state_t           state_n;
  logic [HW-1:0]    hold_cnt;
  logic [HW-1:0]    hold_n;
  logic             core_rst_q;

  assign key_sync = sync1 ^ IDLE_RAW;
  assign accept   = (key_sync != level_q) && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0   <= IDLE_RAW;
      sync1   <= IDLE_RAW;
      deb_cnt <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      count_q <= '0;
    end else begin
      sync0   <= bus.key_raw;
      sync1   <= sync0;
      press_q <= accept && key_sync;
      if (key_sync == level_q) begin
        deb_cnt <= '0;
      end else if (accept) begin
        deb_cnt <= '0;
        level_q <= key_sync;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      if (press_q && (count_q != 8'hff)) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      hold_cnt   <= '0;
      core_rst_q <= 1'b1;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_n;
      core_rst_q <= (state_n != S_RUN);
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    unique case (state)
      S_INIT: begin
        if (level_q) begin
          state_n = S_PRESS;
          hold_n  = '0;
        end else if (hold_cnt != INIT_LAST) begin
          hold_n = hold_cnt + 1'b1;
        end else if (!key_sync) begin
          // a key still held at reset release keeps us here until debounced
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (level_q) state_n = S_PRESS;
      end
      S_PRESS: begin
        if (!level_q) begin
          state_n = S_STRETCH;
          hold_n  = '0;
        end
      end
      S_STRETCH: begin
        if (level_q) begin
          state_n = S_PRESS;
          hold_n  = '0;
        end else if (hold_cnt == STR_LAST) begin
          state_n = S_RUN;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  assign bus.core_rst    = core_rst_q;
  assign bus.key_level   = level_q;
  assign bus.press_pulse = press_q;
  assign bus.reset_count = count_q;

endmodule

// File: tb/tb_key_reset_sequencer.sv
// Directed bench for key_reset_sequencer (default build plus a
// long-hold build used for the re-press-during-stretch case).
module tb_key_reset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_raw = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  key_reset_sequencer_if kif_a ();
  key_reset_sequencer_if kif_b ();

  assign kif_a.key_raw = key_raw;
  assign kif_b.key_raw = key_raw;

  key_reset_sequencer dut_a (
    .clk (clk),
    .rst (rst),
    .bus (kif_a)
  );

  key_reset_sequencer #(
    .RESET_HOLD_CYCLES (16)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (kif_b)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(30);
  endtask

  initial begin
    int lvl_k, rst_k, pulse_k, pulses;
    int fall_k, rfall_k, seen, drop;
    int widths [3];
    widths = '{1, 5, 7};

    // power-up
    tick(3);
    check("rst_core_rst", kif_a.core_rst, 1);
    check("rst_key_level", kif_a.key_level, 0);
    check("rst_press", kif_a.press_pulse, 0);
    check("rst_count", kif_a.reset_count, 0);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check("pwr_core_rst", kif_a.core_rst, (k < 4));
    end
    check("pwr_key_level", kif_a.key_level, 0);
    check("pwr_count", kif_a.reset_count, 0);
    tick(30);

    // clean press and release
    lvl_k = -1; rst_k = -1; pulse_k = -1; pulses = 0;
    key_raw = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (kif_a.key_level && lvl_k < 0) lvl_k = k;
      if (kif_a.core_rst && rst_k < 0) rst_k = k;
      if (kif_a.press_pulse) begin
        pulses++;
        pulse_k = k;
      end
    end
    check("press_level_lat", lvl_k, 10);
    check("press_core_lat", rst_k, 11);
    check("press_pulse_cnt", pulses, 1);
    check("press_pulse_at", pulse_k, 10);
    fall_k = -1; rfall_k = -1; pulses = 0;
    key_raw = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (!kif_a.key_level && fall_k < 0) fall_k = k;
      if (!kif_a.core_rst && rfall_k < 0) rfall_k = k;
      if (kif_a.press_pulse) pulses++;
    end
    check("rel_level_lat", fall_k, 10);
    check("rel_core_lat", rfall_k, 14);
    check("rel_no_pulse", pulses, 0);
    check("press_count", kif_a.reset_count, 1);

    // glitch rejection
    do_reset();
    seen = 0;
    foreach (widths[g]) begin
      key_raw = 1'b0;
      for (int k = 0; k < widths[g]; k++) begin
        tick(1);
        seen |= int'(kif_a.key_level | kif_a.press_pulse | kif_a.core_rst);
      end
      key_raw = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        seen |= int'(kif_a.key_level | kif_a.press_pulse | kif_a.core_rst);
      end
    end
    for (int k = 0; k < 20; k++) begin
      tick(1);
      seen |= int'(kif_a.key_level | kif_a.press_pulse | kif_a.core_rst);
    end
    check("glitch_quiet", seen, 0);
    check("glitch_count", kif_a.reset_count, 0);

    // re-press during stretch (long-hold build)
    do_reset();
    check("rep_idle", kif_b.core_rst, 0);
    key_raw = 1'b0;
    tick(20);
    check("rep_first_rst", kif_b.core_rst, 1);
    key_raw = 1'b1;
    drop = 0;
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      if (!kif_b.core_rst) drop = 1;
    end
    check("rep_released", kif_b.key_level, 0);
    key_raw = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (!kif_b.core_rst) drop = 1;
      if (kif_b.press_pulse) pulses++;
    end
    check("rep_no_dropout", drop, 0);
    check("rep_second_pulse", pulses, 1);
    check("rep_level", kif_b.key_level, 1);
    check("rep_count", kif_b.reset_count, 2);
    key_raw = 1'b1;
    tick(50);
    check("rep_final_run", kif_b.core_rst, 0);

    // rst while held in S_PRESS
    do_reset();
    key_raw = 1'b0;
    tick(20);
    check("mid_pre_rst", kif_a.core_rst, 1);
    check("mid_pre_count", kif_a.reset_count, 1);
    rst = 1'b1;
    tick(1);
    check("mid_level", kif_a.key_level, 0);
    check("mid_count", kif_a.reset_count, 0);
    check("mid_core_rst", kif_a.core_rst, 1);
    rst = 1'b0;
    lvl_k = -1; drop = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (!kif_a.core_rst) drop = 1;
      if (kif_a.key_level && lvl_k < 0) lvl_k = k;
    end
    check("mid_relevel_lat", lvl_k, 10);
    check("mid_no_gap", drop, 0);
    check("mid_recount", kif_a.reset_count, 1);
    key_raw = 1'b1;
    tick(40);
    check("mid_final_run", kif_a.core_rst, 0);

    // saturation
    do_reset();
    for (int i = 1; i <= 260; i++) begin
      key_raw = 1'b0;
      tick(12);
      key_raw = 1'b1;
      tick(12);
      if (i >= 254) check("sat_count", kif_a.reset_count, (i > 255) ? 255 : i);
    end
    tick(20);
    check("sat_hold", kif_a.reset_count, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
